// File: rtl/reg_file_write_arbiter.sv
// rtl/reg_file_write_arbiter.sv - shares the register file write port between the pipeline and a buffered multi-cycle unit
module reg_file_write_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int SEL_WIDTH    = 4,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pipe_wb_valid,
    input  logic [SEL_WIDTH-1:0]      pipe_wb_sel,
    input  logic [DATA_WIDTH-1:0]     pipe_wb_data,
    output logic                      pipe_stall,
    input  logic                      mcu_valid,
    output logic                      mcu_ready,
    input  logic [SEL_WIDTH-1:0]      mcu_sel,
    input  logic [DATA_WIDTH-1:0]     mcu_data,
    output logic                      rf_write_en,
    output logic [SEL_WIDTH-1:0]      rf_write_sel,
    output logic [DATA_WIDTH-1:0]     rf_write_data,
    output logic [2**SEL_WIDTH-1:0]   busy_mask
);
    localparam int NREG = 2**SEL_WIDTH;
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int SW   = $clog2(STARVE_LIMIT + 1);

    logic [SEL_WIDTH-1:0]  fifo_sel  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] slot_valid, slot_valid_next;
    logic [NREG-1:0]       busy_next;
    logic [PW-1:0]         head, tail;
    logic [CW-1:0]         count;
    logic [SW-1:0]         starve_cnt;

    logic pipe_req, fifo_nonempty, force_head, conflict;
    logic push, pop, grant_pipe;

    assign pipe_req      = pipe_wb_valid && (pipe_wb_sel != '0);
    assign fifo_nonempty = (count != '0);
    assign force_head    = (starve_cnt == SW'(STARVE_LIMIT)) && fifo_nonempty;
    assign conflict      = pipe_req && busy_mask[pipe_wb_sel];

    assign mcu_ready  = !rst && (count < CW'(FIFO_DEPTH));
    // sel-0 results are accepted from the unit but never occupy a slot
    assign push       = mcu_valid && mcu_ready && (mcu_sel != '0);
    assign pop        = force_head || conflict || (!pipe_req && fifo_nonempty);
    assign grant_pipe = pipe_req && !(force_head || conflict);
    assign pipe_stall = !rst && pipe_req && (force_head || conflict);

    // Busy mask is rebuilt from the post-edge FIFO contents so it never lags a push or pop
    always_comb begin
        slot_valid_next = '0;
        busy_next       = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            logic                 pushed_here;
            logic [SEL_WIDTH-1:0] sel_after;
            pushed_here        = push && (tail == PW'(i));
            sel_after          = pushed_here ? mcu_sel : fifo_sel[i];
            slot_valid_next[i] = (slot_valid[i] && !(pop && head == PW'(i))) || pushed_here;
            if (slot_valid_next[i]) begin
                busy_next[sel_after] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_sel[tail]  <= mcu_sel;
            fifo_data[tail] <= mcu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            slot_valid    <= '0;
            busy_mask     <= '0;
            starve_cnt    <= '0;
            rf_write_en   <= 1'b0;
            rf_write_sel  <= '0;
            rf_write_data <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            count      <= count + CW'(push) - CW'(pop);
            slot_valid <= slot_valid_next;
            busy_mask  <= busy_next;

            if (pop) begin
                starve_cnt <= '0;
            end else if (grant_pipe && fifo_nonempty && starve_cnt != SW'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end

            if (pop) begin
                rf_write_en   <= 1'b1;
                rf_write_sel  <= fifo_sel[head];
                rf_write_data <= fifo_data[head];
            end else if (grant_pipe) begin
                rf_write_en   <= 1'b1;
                rf_write_sel  <= pipe_wb_sel;
                rf_write_data <= pipe_wb_data;
            end else begin
                rf_write_en   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_reg_file_write_arbiter.sv
// tb/tb_reg_file_write_arbiter.sv - directed scoreboard bench for reg_file_write_arbiter
module tb_reg_file_write_arbiter;
    localparam int DW = 32;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          pipe_wb_valid;
    logic [SW-1:0] pipe_wb_sel;
    logic [DW-1:0] pipe_wb_data;
    logic          pipe_stall;
    logic          mcu_valid;
    logic          mcu_ready;
    logic [SW-1:0] mcu_sel;
    logic [DW-1:0] mcu_data;
    logic          rf_write_en;
    logic [SW-1:0] rf_write_sel;
    logic [DW-1:0] rf_write_data;
    logic [15:0]   busy_mask;

    int checks = 0;
    int errors = 0;
    logic [SW-1:0] q_sel  [$];
    logic [DW-1:0] q_data [$];

    reg_file_write_arbiter #(
        .DATA_WIDTH(DW), .SEL_WIDTH(SW), .FIFO_DEPTH(2), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .pipe_wb_valid(pipe_wb_valid), .pipe_wb_sel(pipe_wb_sel), .pipe_wb_data(pipe_wb_data),
        .pipe_stall(pipe_stall),
        .mcu_valid(mcu_valid), .mcu_ready(mcu_ready), .mcu_sel(mcu_sel), .mcu_data(mcu_data),
        .rf_write_en(rf_write_en), .rf_write_sel(rf_write_sel), .rf_write_data(rf_write_data),
        .busy_mask(busy_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [SW-1:0] ps, input logic [DW-1:0] pd,
                         input logic mv, input logic [SW-1:0] ms, input logic [DW-1:0] md);
        pipe_wb_valid = pv; pipe_wb_sel = ps; pipe_wb_data = pd;
        mcu_valid = mv; mcu_sel = ms; mcu_data = md;
    endtask

    task automatic expect_wr(input logic [SW-1:0] s, input logic [DW-1:0] d);
        q_sel.push_back(s);
        q_data.push_back(d);
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    // Every register file write must match the oldest outstanding expectation
    always @(posedge clk) begin
        #1;
        if (rf_write_en === 1'b1) begin
            if (q_sel.size() == 0) begin
                chk("sb_unexpected_write", rf_write_en, 0);
            end else begin
                chk("sb_sel", rf_write_sel, q_sel.pop_front());
                chk("sb_data", rf_write_data, q_data.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        next(); next();
        chk("rst_wen", rf_write_en, 0);
        chk("rst_sel", rf_write_sel, 0);
        chk("rst_data", rf_write_data, 0);
        chk("rst_busy", busy_mask, 0);
        chk("rst_ready", mcu_ready, 0);
        chk("rst_stall", pipe_stall, 0);
        rst = 1'b0;
        #1 chk("post_rst_ready", mcu_ready, 1);

        // Plain pipeline write
        drive(1, 3, 32'hDEADBEEF, 0, 0, 0);
        expect_wr(3, 32'hDEADBEEF);
        #1 chk("t1_stall", pipe_stall, 0);
        next();
        drive(0, 0, 0, 0, 0, 0);
        #1 chk("t1_stall_idle", pipe_stall, 0);
        next();
        chk("t1_wen_off", rf_write_en, 0);
        chk("t1_sel_hold", rf_write_sel, 3);
        chk("t1_data_hold", rf_write_data, 32'hDEADBEEF);

        // Two MCU pushes while the pipeline keeps the port busy, then drain in order
        drive(1, 1, 32'h100, 1, 5, 32'h11);
        expect_wr(1, 32'h100);
        #1 chk("t2_ready0", mcu_ready, 1);
        next();
        chk("t2_busy1", busy_mask, 16'h0020);
        drive(1, 1, 32'h101, 1, 7, 32'h22);
        expect_wr(1, 32'h101);
        #1 chk("t2_ready1", mcu_ready, 1);
        chk("t2_stall", pipe_stall, 0);
        next();
        chk("t2_busy_a0", busy_mask, 16'h00A0);
        chk("t2_ready_full", mcu_ready, 0);
        drive(0, 0, 0, 0, 0, 0);
        expect_wr(5, 32'h11);
        next();
        chk("t2_busy_80", busy_mask, 16'h0080);
        expect_wr(7, 32'h22);
        next();
        chk("t2_busy_00", busy_mask, 16'h0000);

        // Starvation relief after four pipeline grants
        drive(0, 0, 0, 1, 9, 32'h99);
        next();
        chk("t3_busy", busy_mask, 16'h0200);
        for (int i = 0; i < 4; i++) begin
            drive(1, 2, 32'h200 + i, 0, 0, 0);
            expect_wr(2, 32'h200 + i);
            #1 chk("t3_stall_pre", pipe_stall, 0);
            next();
        end
        drive(1, 2, 32'h205, 0, 0, 0);
        expect_wr(9, 32'h99);
        #1 chk("t3_stall_force", pipe_stall, 1);
        next();
        chk("t3_busy_clear", busy_mask, 0);
        #1 chk("t3_stall_after", pipe_stall, 0);
        expect_wr(2, 32'h205);
        next();
        drive(0, 0, 0, 0, 0, 0);
        next();

        // WAW: pipeline write to a register with a pending MCU result
        drive(0, 0, 0, 1, 4, 32'hAA);
        next();
        chk("t4_busy", busy_mask, 16'h0010);
        drive(1, 4, 32'hBB, 0, 0, 0);
        expect_wr(4, 32'hAA);
        #1 chk("t4_stall", pipe_stall, 1);
        next();
        chk("t4_busy_clear", busy_mask, 0);
        #1 chk("t4_stall_release", pipe_stall, 0);
        expect_wr(4, 32'hBB);
        next();
        drive(0, 0, 0, 0, 0, 0);
        next();

        // Register-0 cases
        drive(0, 0, 0, 1, 0, 32'h55);
        #1 chk("t5_ready", mcu_ready, 1);
        next();
        drive(0, 0, 0, 0, 0, 0);
        chk("t5_busy", busy_mask, 0);
        chk("t5_no_wr", rf_write_en, 0);
        #1 chk("t5_ready_after", mcu_ready, 1);
        drive(1, 0, 32'h77, 0, 0, 0);
        #1 chk("t5_pipe0_stall", pipe_stall, 0);
        next();
        chk("t5_pipe0_no_wr", rf_write_en, 0);
        drive(0, 0, 0, 1, 6, 32'h66);
        next();
        drive(1, 0, 32'h88, 0, 0, 0);
        expect_wr(6, 32'h66);
        #1 chk("t5_head_stall", pipe_stall, 0);
        next();
        drive(0, 0, 0, 0, 0, 0);
        chk("t5_busy_end", busy_mask, 0);

        // Reset with a full FIFO discards its contents
        drive(1, 1, 32'h300, 1, 10, 32'hA);
        expect_wr(1, 32'h300);
        next();
        drive(1, 1, 32'h301, 1, 11, 32'hB);
        expect_wr(1, 32'h301);
        next();
        chk("t6_full_ready", mcu_ready, 0);
        chk("t6_full_busy", busy_mask, 16'h0C00);
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1 chk("t6_rst_ready", mcu_ready, 0);
        chk("t6_rst_stall", pipe_stall, 0);
        next();
        chk("t6_busy", busy_mask, 0);
        chk("t6_wen", rf_write_en, 0);
        chk("t6_sel", rf_write_sel, 0);
        rst = 1'b0;
        #1 chk("t6_ready_after", mcu_ready, 1);
        repeat (4) next();
        chk("t6_still_empty", busy_mask, 0);
        chk("sb_drained", q_sel.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
